// File: rtl/cd_i2s_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cd_i2s_feeder: FIFO-buffered CD sample serializer for Butch I2S rx  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cd_i2s_feeder #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          en,
  input  logic          flush,
  input  logic          sck,
  input  logic          ws,
  input  logic [31:0]   din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          i2rxd,
  output logic [CW-1:0] level,
  output logic          underrun,
  output logic [15:0]   underrun_cnt
);

  localparam int            AW           = $clog2(DEPTH);
  localparam logic [CW-1:0] c_full_level = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_level;
  logic          r_sck_d;
  logic          r_ws_q;
  logic          r_ws_used;
  logic [31:0]   r_hold;
  logic [15:0]   r_shift;
  logic          r_underrun;
  logic [15:0]   r_underrun_cnt;
  state_t        r_state;

  logic          w_rise;
  logic          w_fall;
  logic          w_boundary;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_left_load;
  logic          w_underrun_nxt;
  logic          w_ws_used_nxt;
  logic [31:0]   w_hold_nxt;
  logic [15:0]   w_shift_nxt;
  state_t        w_state_nxt;

  assign w_rise     = ~r_sck_d & sck;
  assign w_fall     = r_sck_d & ~sck;
  assign w_boundary = (r_ws_q != r_ws_used);
  assign w_empty    = (r_level == '0);

  // Ready is taken from the registered level, so a pop never frees a slot
  // for a push in the same cycle.
  assign din_ready = (r_level != c_full_level) & ~flush;
  assign w_push    = din_valid & din_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_hold_nxt     = r_hold;
    w_ws_used_nxt  = r_ws_used;
    w_left_load    = 1'b0;
    w_pop          = 1'b0;
    w_underrun_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_shift_nxt = '0;
        if (en) w_state_nxt = S_SYNC;
      end
      S_SYNC: begin
        w_shift_nxt = '0;
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (w_fall && w_boundary) begin
          w_ws_used_nxt = r_ws_q;
          if (!r_ws_q) begin
            w_state_nxt = S_RUN;
            w_left_load = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
          w_shift_nxt = '0;
        end else if (w_fall) begin
          if (w_boundary) begin
            w_ws_used_nxt = r_ws_q;
            if (!r_ws_q) w_left_load = 1'b1;
            else         w_shift_nxt = r_hold[15:0];
          end else begin
            w_shift_nxt = {r_shift[14:0], 1'b0};
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_shift_nxt = '0;
      end
    endcase

    if (w_left_load) begin
      if (!w_empty) begin
        w_pop      = 1'b1;
        w_hold_nxt = r_mem[r_rptr];
      end else begin
        w_hold_nxt     = '0;
        w_underrun_nxt = 1'b1;
      end
      w_shift_nxt = w_hold_nxt[31:16];
    end

    if (flush) begin
      w_state_nxt    = en ? S_SYNC : S_IDLE;
      w_shift_nxt    = '0;
      w_hold_nxt     = r_hold;
      w_ws_used_nxt  = r_ws_used;
      w_pop          = 1'b0;
      w_underrun_nxt = 1'b0;
    end
  end

  // Storage array carries no reset; only pointers and level define contents.
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_level        <= '0;
      r_sck_d        <= 1'b0;
      r_ws_q         <= 1'b0;
      r_ws_used      <= 1'b0;
      r_hold         <= '0;
      r_shift        <= '0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
      r_state        <= S_IDLE;
    end else begin
      r_sck_d    <= sck;
      if (w_rise) r_ws_q <= ws;
      r_ws_used  <= w_ws_used_nxt;
      r_hold     <= w_hold_nxt;
      r_shift    <= w_shift_nxt;
      r_state    <= w_state_nxt;
      r_underrun <= w_underrun_nxt;
      if (w_underrun_nxt && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;

      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + CW'(1);
          2'b01:   r_level <= r_level - CW'(1);
          default: r_level <= r_level;
        endcase
      end
    end
  end

  assign i2rxd        = r_shift[15];
  assign level        = r_level;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;

endmodule
`default_nettype wire

// File: doc/cd_i2s_feeder.md
Name: cd_i2s_feeder

Overview:
- Upstream stage of the Butch I2S receiver.
- Buffers 32-bit stereo CD audio/data samples (left in [31:16], right in [15:0]) from the drive-emulation logic in a small FIFO.
- Serializes them MSB-first onto `i2rxd`, bit-synchronous to the `sck`/`ws` pair generated by Butch (`sckout`/`wsout`).
- Guarantees L/R pair alignment and reports underruns.

Parameters:
- DEPTH, 8, FIFO depth in 32-bit entries; power of two, minimum 2.
- CW, 4, width of level output; equals log2(DEPTH)+1.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  serializer enable.
- flush  in  1  one-cycle FIFO clear plus resync.
- sck  in  1  I2S bit clock (Butch `sckout`), slow relative to `sys_clk`.
- ws  in  1  word select (Butch `wsout`); 0 = left, 1 = right.
- din  in  32  sample {L[15:0], R[15:0]}.
- din_valid  in  1  producer has a sample.
- din_ready  out  1  FIFO can accept; equals ~full.
- i2rxd  out  1  serial data to Butch.
- level  out  CW  FIFO occupancy, 0..DEPTH.
- underrun  out  1  one-cycle pulse on an empty-FIFO left boundary.
- underrun_cnt  out  16  saturating underrun count.

Behaviour:
- Reset: on `sys_clk` with `reset`=1, all state clears:
  - FIFO pointers and `level` = 0.
  - `i2rxd`, `underrun`, `underrun_cnt`, shifter, hold register and the edge-detect flops = 0.
  - FSM = IDLE.
  - `din_ready` = 1 from the first cycle after reset deasserts.
- Edge detect: `sck_d` <= `sck` each cycle.
  - rise = ~`sck_d` & `sck`.
  - fall = `sck_d` & ~`sck`.
  - Only one event per cycle is possible.
- WS sampling: on rise, `ws_q` <= `ws`.
  - `ws_used` holds the `ws_q` value at the last load.
  - boundary = (`ws_q` != `ws_used`), evaluated at fall.
- Push: when `din_valid` & `din_ready`, write `din` at wptr and increment wptr (wraps at DEPTH).
- Pop:
  - Happens only at a left boundary in RUN.
  - Reads the rptr entry into the 32-bit hold register and increments rptr.
  - Simultaneous push and pop in one cycle leaves `level` unchanged.
  - `din_ready` is derived from registered `level`; push at full is refused even if a pop occurs in the same cycle.
- FSM:
  - IDLE:
    - `i2rxd` = 0, shifter = 0, no pops.
    - `en`=1 goes to SYNC.
  - SYNC:
    - Waits for a fall with boundary where `ws_q`=0 (start of left word); updates `ws_used` on every boundary.
    - On that left boundary, goes to RUN and performs the left load in the same cycle.
    - `en`=0 goes to IDLE.
  - RUN, on fall:
    - Left boundary (`ws_q`=0):
      - If FIFO non-empty: pop into hold; shifter <= hold_new[31:16].
      - If FIFO empty: hold <= 0; shifter <= 0; `underrun` pulses 1 cycle; `underrun_cnt` increments, saturating at 16'hFFFF.
    - Right boundary (`ws_q`=1): shifter <= hold[15:0]; no pop.
    - No boundary: shifter <= {shifter[14:0], 0}.
    - `en`=0 goes to IDLE; the current word is abandoned and `i2rxd` = 0 next cycle.
- Output:
  - `i2rxd` = shifter[15], registered, so it changes only on the cycle after a fall.
  - First bit after a WS transition = MSB (one-bit I2S delay relative to Butch's WS sampling on rise).
  - Bits beyond 16 in a 32-bit slot = 0.
- Flush:
  - Priority over push/pop: clears pointers and `level`, sets the FSM to SYNC if `en`, otherwise IDLE.
  - `underrun_cnt` is kept.
  - A push asserted in the flush cycle is dropped; `din_ready` = 0 during that cycle.
- Reset mid-word: the serial stream stops immediately (`i2rxd`=0 next cycle).
- `level` always equals pushes minus pops modulo flush; it never exceeds DEPTH and never underflows.

Test Plan:
- Reset, `en`=1, push 32'h8001_7FFE, drive 16 sck cycles per ws half (ws 1->0 start) → left slot `i2rxd` sequence 1000_0000_0000_0001, right slot 0111_1111_1111_1110; `level` 1→0 at left boundary.
- `en`=1 with FIFO empty for 3 left boundaries → `i2rxd` constant 0; `underrun` pulses 3 times; `underrun_cnt`=3; then push 32'hFFFF_0000 → next left word all ones, right all zeros.
- Push 8 samples with DEPTH=8, no sck → `level`=8, `din_ready`=0; ninth `din_valid` ignored; one left boundary pop with concurrent `din_valid` → push refused that cycle, `level`=7, `din_ready`=1 next cycle.
- `en` rises while `ws`=1 mid-right-word → no pop, `i2rxd`=0 until first ws 1→0 boundary, then the L word of entry 0 appears; R of the same entry follows.
- `flush` with `level`=5 and `din_valid`=1 in the same cycle → `level`=0, no write; FSM resyncs; `underrun_cnt` unchanged.
- Force `underrun_cnt`=16'hFFFE, cause 3 underruns → saturates at 16'hFFFF; assert `reset` mid-bit → `i2rxd`=0, `level`=0, `underrun_cnt`=0 next cycle.
